// File: rtl/ncc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : ncc_stream
//  Purpose  : Streaming normalized-cross-correlation matcher. Loads one
//             PATCH x PATCH descriptor over a LANES-wide word stream, then
//             scores NUM_WIN candidate patches streamed behind it. The best
//             candidate is tracked with a divider-free cross-multiplied
//             comparison: num^2 * best_wsos > best_num^2 * wsos.
//  Revision : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     system clock, rising edge
//    rst                     asynchronous active-high reset
//    start                   one-cycle pulse, begins a search from IDLE
//    desc_valid/desc_ready   descriptor beat handshake
//    desc_data               LANES pixels, lane 0 in the MSBs, raster order
//    win_valid/win_ready     candidate beat handshake
//    win_data                LANES candidate pixels, same packing
//    busy                    high from start acceptance through DONE
//    done                    one-cycle pulse when results are final
//    best_valid              at least one candidate qualified
//    best_idx                arrival index of the best candidate
//    best_num / best_wsos    sum(d*w) / sum(w^2) of the best candidate
//    desc_sos                sum(d^2) of the loaded descriptor
//  Optional (macro NCC_CAND_OUT_EN defined)
//    cand_valid              pulses in each COMPARE cycle
//    cand_num / cand_wsos    sums of the candidate being compared
// ============================================================================
module ncc_stream #(
   parameter  int PIX_W   = 8,
   parameter  int PATCH   = 16,
   parameter  int LANES   = 4,
   parameter  int NUM_WIN = 289,
   localparam int N       = PATCH * PATCH,
   localparam int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
   localparam int ACC_W   = 2 * PIX_W + $clog2(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   desc_valid,
   output logic                   desc_ready,
   input  logic [LANES*PIX_W-1:0] desc_data,
   input  logic                   win_valid,
   output logic                   win_ready,
   input  logic [LANES*PIX_W-1:0] win_data,
   output logic                   busy,
   output logic                   done,
   output logic                   best_valid,
   output logic [IDX_W-1:0]       best_idx,
   output logic [ACC_W-1:0]       best_num,
   output logic [ACC_W-1:0]       best_wsos,
`ifdef NCC_CAND_OUT_EN
   output logic                   cand_valid,
   output logic [ACC_W-1:0]       cand_num,
   output logic [ACC_W-1:0]       cand_wsos,
`endif
   output logic [ACC_W-1:0]       desc_sos
);

   localparam int BEATS  = N / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PROD_W = 3 * ACC_W;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_DESC = 3'd1,
      SEARCH    = 3'd2,
      COMPARE   = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [LANES*PIX_W-1:0] desc_buf [BEATS];
   logic [BEAT_W-1:0]      beat;
   logic [IDX_W-1:0]       idx;
   logic [ACC_W-1:0]       num;
   logic [ACC_W-1:0]       wsos;

   logic                   desc_fire;
   logic                   win_fire;
   logic                   last_beat;
   logic                   last_win;
   logic [LANES*PIX_W-1:0] desc_word;
   logic [ACC_W-1:0]       beat_dsos;
   logic [ACC_W-1:0]       beat_num;
   logic [ACC_W-1:0]       beat_wsos;
   logic [PROD_W-1:0]      cand_score;
   logic [PROD_W-1:0]      best_score;
   logic                   qualifies;
   logic                   take_cand;

   // Lane-wise dot product of two packed beats. Lane order does not matter
   // for the sum as long as both operands use the same packing.
   function automatic logic [ACC_W-1:0] beat_dot(
      input logic [LANES*PIX_W-1:0] a,
      input logic [LANES*PIX_W-1:0] b
   );
      logic [ACC_W-1:0] s;
      s = '0;
      for (int l = 0; l < LANES; l++) begin
         s = s + ACC_W'(a[l*PIX_W +: PIX_W]) * ACC_W'(b[l*PIX_W +: PIX_W]);
      end
      return s;
   endfunction

   assign desc_fire = desc_valid && desc_ready;
   assign win_fire  = win_valid && win_ready;
   assign last_beat = (beat == BEAT_W'(BEATS - 1));
   assign last_win  = (idx == IDX_W'(NUM_WIN - 1));

   // The descriptor pixel at the same raster position as the incoming
   // candidate beat lives in the buffer word addressed by the beat counter.
   assign desc_word = desc_buf[beat];
   assign beat_dsos = beat_dot(desc_data, desc_data);
   assign beat_num  = beat_dot(desc_word, win_data);
   assign beat_wsos = beat_dot(win_data, win_data);

   // NCC(cand) > NCC(best) <=> num^2*best_wsos > best_num^2*wsos once both
   // nums are positive; desc_sos is common to both sides and cancels.
   assign cand_score = PROD_W'(num) * PROD_W'(num) * PROD_W'(best_wsos);
   assign best_score = PROD_W'(best_num) * PROD_W'(best_num) * PROD_W'(wsos);
   assign qualifies  = (num != '0) && (wsos != '0);
   // Strict greater-than keeps the earlier index on a tie.
   assign take_cand  = qualifies && (!best_valid || (cand_score > best_score));

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and handshake / status outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      desc_ready = 1'b0;
      win_ready  = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = LOAD_DESC;
            end
         end
         LOAD_DESC: begin
            desc_ready = 1'b1;
            if (desc_fire && last_beat) begin
               state_nxt = SEARCH;
            end
         end
         SEARCH: begin
            win_ready = 1'b1;
            if (win_fire && last_beat) begin
               state_nxt = COMPARE;
            end
         end
         COMPARE: begin
            state_nxt = last_win ? DONE : SEARCH;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Descriptor buffer: contents are don't-care after reset, so no reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (desc_fire) begin
         desc_buf[beat] <= desc_data;
      end
   end

   // ------------------------------------------------------------------------
   // Accumulators, counters and best-candidate tracking
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat       <= '0;
         idx        <= '0;
         num        <= '0;
         wsos       <= '0;
         desc_sos   <= '0;
         best_valid <= 1'b0;
         best_idx   <= '0;
         best_num   <= '0;
         best_wsos  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  beat       <= '0;
                  idx        <= '0;
                  num        <= '0;
                  wsos       <= '0;
                  desc_sos   <= '0;
                  best_valid <= 1'b0;
                  best_idx   <= '0;
                  best_num   <= '0;
                  best_wsos  <= '0;
               end
            end
            LOAD_DESC: begin
               if (desc_fire) begin
                  desc_sos <= desc_sos + beat_dsos;
                  beat     <= last_beat ? '0 : beat + BEAT_W'(1);
               end
            end
            SEARCH: begin
               if (win_fire) begin
                  num  <= num + beat_num;
                  wsos <= wsos + beat_wsos;
                  beat <= last_beat ? '0 : beat + BEAT_W'(1);
               end
            end
            COMPARE: begin
               if (take_cand) begin
                  best_valid <= 1'b1;
                  best_idx   <= idx;
                  best_num   <= num;
                  best_wsos  <= wsos;
               end
               num  <= '0;
               wsos <= '0;
               idx  <= idx + IDX_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

`ifdef NCC_CAND_OUT_EN
   // The accumulators still hold the candidate's totals during COMPARE and
   // are zero in reset, so the observation ports follow them directly.
   assign cand_valid = (state == COMPARE);
   assign cand_num   = num;
   assign cand_wsos  = wsos;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ncc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ncc_stream
//  Purpose  : Self-checking bench for ncc_stream (PATCH=4, LANES=2,
//             NUM_WIN=4). Directed patterns plus randomized pixels and
//             handshake gaps, scored against a software cross-multiplied
//             reference computed from plain pixel arrays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ncc_stream;

   localparam int PIX_W   = 8;
   localparam int PATCH   = 4;
   localparam int LANES   = 2;
   localparam int NUM_WIN = 4;
   localparam int N       = PATCH * PATCH;
   localparam int BEATS   = N / LANES;
   localparam int IDX_W   = 2;
   localparam int ACC_W   = 2 * PIX_W + $clog2(N);
   localparam int HS_MAX  = 200;

   logic                   clk;
   logic                   rst;
   logic                   start;
   logic                   desc_valid;
   logic                   desc_ready;
   logic [LANES*PIX_W-1:0] desc_data;
   logic                   win_valid;
   logic                   win_ready;
   logic [LANES*PIX_W-1:0] win_data;
   logic                   busy;
   logic                   done;
   logic                   best_valid;
   logic [IDX_W-1:0]       best_idx;
   logic [ACC_W-1:0]       best_num;
   logic [ACC_W-1:0]       best_wsos;
   logic [ACC_W-1:0]       desc_sos;

   ncc_stream #(
      .PIX_W   (PIX_W),
      .PATCH   (PATCH),
      .LANES   (LANES),
      .NUM_WIN (NUM_WIN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_data  (desc_data),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .busy       (busy),
      .done       (done),
      .best_valid (best_valid),
      .best_idx   (best_idx),
      .best_num   (best_num),
      .best_wsos  (best_wsos),
      .desc_sos   (desc_sos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int passes;
   int fails;
   int hs_timeouts;
   int done_total;

   int unsigned dpx [N];
   int unsigned cpx [NUM_WIN][N];

   logic              exp_valid;
   int                exp_idx;
   longint unsigned   exp_num;
   longint unsigned   exp_wsos;
   longint unsigned   exp_dsos;

   always @(negedge clk) begin
      if (done === 1'b1) done_total <= done_total + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: full-patch sums, then keep the candidate whose NCC^2 is
   // strictly larger via cross multiplication (first one wins ties).
   task automatic model();
      longint unsigned n, w, bn, bw;
      bit bv;
      int bi;
      exp_dsos = 0;
      for (int i = 0; i < N; i++) exp_dsos += dpx[i] * dpx[i];
      bv = 0; bi = 0; bn = 0; bw = 0;
      for (int k = 0; k < NUM_WIN; k++) begin
         n = 0; w = 0;
         for (int i = 0; i < N; i++) begin
            n += dpx[i] * cpx[k][i];
            w += cpx[k][i] * cpx[k][i];
         end
         if (n > 0 && w > 0 && (!bv || n * n * bw > bn * bn * w)) begin
            bv = 1; bi = k; bn = n; bw = w;
         end
      end
      exp_valid = bv;
      exp_idx   = bi;
      exp_num   = bn;
      exp_wsos  = bw;
   endtask

   function automatic logic [LANES*PIX_W-1:0] pack_desc(input int b);
      logic [LANES*PIX_W-1:0] word;
      for (int l = 0; l < LANES; l++)
         word[(LANES-1-l)*PIX_W +: PIX_W] = PIX_W'(dpx[b*LANES+l]);
      return word;
   endfunction

   function automatic logic [LANES*PIX_W-1:0] pack_win(input int k, input int b);
      logic [LANES*PIX_W-1:0] word;
      for (int l = 0; l < LANES; l++)
         word[(LANES-1-l)*PIX_W +: PIX_W] = PIX_W'(cpx[k][b*LANES+l]);
      return word;
   endfunction

   // One beat: present data at a negedge, hold until ready is seen high
   // mid-cycle, so the following rising edge accepts it.
   task automatic push(input bit is_win, input logic [LANES*PIX_W-1:0] data, input int gap);
      int cnt;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      if (is_win) begin win_data = data; win_valid = 1'b1; end
      else        begin desc_data = data; desc_valid = 1'b1; end
      cnt = 0;
      while (!(is_win ? win_ready : desc_ready) && cnt < HS_MAX) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= HS_MAX) hs_timeouts++;
      @(posedge clk);
      #1;
      desc_valid = 1'b0;
      win_valid  = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_desc(input int maxgap);
      for (int b = 0; b < BEATS; b++)
         push(1'b0, pack_desc(b), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic send_cand(input int k, input int nbeats, input int maxgap);
      for (int b = 0; b < nbeats; b++)
         push(1'b1, pack_win(k, b), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_desc_ready"}, desc_ready, 0);
      check({pfx, "_win_ready"},  win_ready, 0);
      check({pfx, "_busy"},       busy, 0);
      check({pfx, "_done"},       done, 0);
      check({pfx, "_best_valid"}, best_valid, 0);
      check({pfx, "_best_idx"},   best_idx, 0);
      check({pfx, "_best_num"},   best_num, 0);
      check({pfx, "_best_wsos"},  best_wsos, 0);
      check({pfx, "_desc_sos"},   desc_sos, 0);
   endtask

   // Complete search with cycle-exact checks around COMPARE and DONE.
   // poke=1 also pulses start while busy and in the DONE cycle.
   task automatic run_search(input string pfx, input int maxgap, input bit poke);
      int d0;
      model();
      hs_timeouts = 0;
      d0 = done_total;
      pulse_start();
      check({pfx, "_busy_after_start"}, busy, 1);
      check({pfx, "_desc_ready_after_start"}, desc_ready, 1);
      send_desc(maxgap);
      if (poke) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      for (int k = 0; k < NUM_WIN; k++) send_cand(k, BEATS, maxgap);
      @(negedge clk);
      check({pfx, "_cmp_win_ready"}, win_ready, 0);
      check({pfx, "_cmp_done"}, done, 0);
      @(negedge clk);
      if (poke) start = 1'b1;
      check({pfx, "_done_pulse"}, done, 1);
      check({pfx, "_done_busy"}, busy, 1);
      check({pfx, "_best_valid"}, best_valid, exp_valid);
      check({pfx, "_best_idx"}, best_idx, exp_idx);
      check({pfx, "_best_num"}, best_num, exp_num);
      check({pfx, "_best_wsos"}, best_wsos, exp_wsos);
      check({pfx, "_desc_sos"}, desc_sos, exp_dsos);
      @(negedge clk);
      start = 1'b0;
      check({pfx, "_post_done"}, done, 0);
      check({pfx, "_post_busy"}, busy, 0);
      check({pfx, "_post_desc_ready"}, desc_ready, 0);
      repeat (3) @(negedge clk);
      check({pfx, "_idle_busy"}, busy, 0);
      check({pfx, "_done_count"}, done_total - d0, 1);
      check({pfx, "_hold_idx"}, best_idx, exp_idx);
      check({pfx, "_handshake"}, hs_timeouts, 0);
   endtask

   task automatic load_t1();
      for (int i = 0; i < N; i++) dpx[i] = 3 + (i % 4);
      for (int k = 0; k < NUM_WIN; k++)
         for (int i = 0; i < N; i++) cpx[k][i] = 2;
   endtask

   initial begin
      int d0;
      checks = 0; passes = 0; fails = 0; hs_timeouts = 0; done_total = 0;
      rst = 1'b1; start = 1'b0;
      desc_valid = 1'b0; win_valid = 1'b0;
      desc_data = '0; win_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Test 1: descriptor {3,4,5,6} repeated, every candidate all 2 -> all tie
      load_t1();
      run_search("t1", 0, 1'b0);
      check("t1_const_dsos", desc_sos, 344);
      check("t1_const_num", best_num, 144);
      check("t1_const_wsos", best_wsos, 64);
      check("t1_const_idx", best_idx, 0);

      // Test 2: descriptor all 2; candidates 0,1,2,0 -> 1 and 2 tie, 1 kept
      for (int i = 0; i < N; i++) begin
         dpx[i] = 2; cpx[0][i] = 0; cpx[1][i] = 1; cpx[2][i] = 2; cpx[3][i] = 0;
      end
      run_search("t2", 0, 1'b0);
      check("t2_const_idx", best_idx, 1);
      check("t2_const_num", best_num, 32);
      check("t2_const_wsos", best_wsos, 16);

      // Test 3: no candidate qualifies
      for (int k = 0; k < NUM_WIN; k++)
         for (int i = 0; i < N; i++) cpx[k][i] = 0;
      run_search("t3", 0, 1'b0);
      check("t3_const_valid", best_valid, 0);

      // Test 4: random pixels with random handshake gaps
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) dpx[i] = $urandom_range(0, 255);
         for (int k = 0; k < NUM_WIN; k++)
            for (int i = 0; i < N; i++)
               cpx[k][i] = (r == 2 && k == 0) ? 0 : $urandom_range(0, 255);
         run_search($sformatf("rnd%0d", r), 3, 1'b0);
      end

      // Test 5: reset during candidate 2, then rerun test 1
      load_t1();
      d0 = done_total;
      pulse_start();
      send_desc(0);
      send_cand(0, BEATS, 1);
      send_cand(1, BEATS, 1);
      send_cand(2, 3, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_done", done_total - d0, 0);
      run_search("t5", 0, 1'b0);
      check("t5_const_dsos", desc_sos, 344);
      check("t5_const_num", best_num, 144);

      // Test 6: start pulses while busy and in the DONE cycle are ignored
      for (int i = 0; i < N; i++) begin
         dpx[i] = 2; cpx[0][i] = 0; cpx[1][i] = 1; cpx[2][i] = 2; cpx[3][i] = 0;
      end
      run_search("t6", 1, 1'b1);
      check("t6_const_idx", best_idx, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
